alu_iter: RTL and testbench



---
 rtl/alu_iter_if.sv | 25 ++
 rtl/alu_iter.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_iter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_if.sv
// Handshake bundle for alu_iter: request side (in_*, A, B, op) and result side (out_*, comp, err).
interface alu_iter_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [2:0]       comp;
  logic             err;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, out, comp, err
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, out, comp, err
  );
endinterface

// File: rtl/alu_iter.sv
// Handshaked ALU with iterative multiply and (when ALU_ITER_DIV_EN is defined) restoring
// unsigned divide/remainder. Without ALU_ITER_DIV_EN, divu/remu take the undefined-op path.
module alu_iter #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  alu_iter_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out;
  logic [2:0]       r_comp;
  logic             r_err;

  logic             w_accept;
  logic             w_multi;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic [WIDTH-1:0] w_mul_nxt;
  logic [WIDTH-1:0] w_iter_res;

`ifdef ALU_ITER_DIV_EN
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_df;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
`endif

  // Signed three-way compare, exactly one flag set: {gt, eq, lt}.
  function automatic logic [2:0] cmp_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2:0] f;
    if ($signed(a) > $signed(b)) begin
      f = 3'b100;
    end else if (a == b) begin
      f = 3'b010;
    end else begin
      f = 3'b001;
    end
    return f;
  endfunction

  assign w_accept      = bus.in_valid & r_in_ready;
  assign w_shamt       = bus.B[SHW-1:0];
  assign w_sra         = $signed(bus.A) >>> w_shamt;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.comp      = r_comp;
  assign bus.err       = r_err;

  // Decide whether the presented op needs the iterative engine.
  always_comb begin
    w_multi = 1'b0;
    case (bus.op)
      OP_MUL:  w_multi = 1'b1;
`ifdef ALU_ITER_DIV_EN
      OP_DIVU,
      OP_REMU: w_multi = (bus.B != {WIDTH{1'b0}});
`endif
      default: w_multi = 1'b0;
    endcase
  end

  // Single-cycle result and error for the presented request, including divide by zero.
  always_comb begin
    w_res = {WIDTH{1'b0}};
    w_err = 1'b0;
    case (bus.op)
      OP_ADD:  w_res = bus.A + bus.B;
      OP_SUB:  w_res = bus.A - bus.B;
      OP_AND:  w_res = bus.A & bus.B;
      OP_OR:   w_res = bus.A | bus.B;
      OP_XOR:  w_res = bus.A ^ bus.B;
      OP_NOT:  w_res = ~bus.A;
      OP_SHL:  w_res = bus.A << w_shamt;
      OP_SHR:  w_res = bus.A >> w_shamt;
      OP_SRA:  w_res = w_sra;
      OP_MUL:  w_res = {WIDTH{1'b0}};
`ifdef ALU_ITER_DIV_EN
      OP_DIVU: begin
        w_res = {WIDTH{1'b1}};
        w_err = 1'b1;
      end
      OP_REMU: begin
        w_res = bus.A;
        w_err = 1'b1;
      end
`endif
      default: begin
        w_res = {WIDTH{1'b0}};
        w_err = 1'b1;
      end
    endcase
  end

  // MSB-first shift-add: acc = 2*acc + (B[cnt] ? A : 0), kept to WIDTH bits.
  assign w_mul_nxt = {r_acc[WIDTH-2:0], 1'b0} + (r_b[r_cnt] ? r_a : {WIDTH{1'b0}});

`ifdef ALU_ITER_DIV_EN
  // Restoring step: bring in dividend bit cnt, keep the difference only when it does not borrow.
  assign w_div_sh  = {r_rem, r_a[r_cnt]};
  assign w_div_df  = w_div_sh - {1'b0, r_b};
  assign w_div_ok  = ~w_div_df[WIDTH];
  assign w_rem_nxt = w_div_ok ? w_div_df[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_acc[WIDTH-2:0], w_div_ok};
`endif

  // Result of the final iteration, selected by the captured op.
  always_comb begin
    w_iter_res = {WIDTH{1'b0}};
    case (r_op)
      OP_MUL:  w_iter_res = w_mul_nxt;
`ifdef ALU_ITER_DIV_EN
      OP_DIVU: w_iter_res = w_quo_nxt;
      OP_REMU: w_iter_res = w_rem_nxt;
`endif
      default: w_iter_res = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic for IDLE/BUSY/DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_multi ? S_BUSY : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == {SHW{1'b0}}) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with registered handshake flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Operand capture, iteration datapath and result registers (written only on DONE entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_op   <= 4'b0000;
      r_cnt  <= {SHW{1'b0}};
      r_acc  <= {WIDTH{1'b0}};
      r_out  <= {WIDTH{1'b0}};
      r_comp <= 3'b000;
      r_err  <= 1'b0;
`ifdef ALU_ITER_DIV_EN
      r_rem  <= {WIDTH{1'b0}};
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_op  <= bus.op;
            r_cnt <= SHW'(WIDTH - 1);
            r_acc <= {WIDTH{1'b0}};
`ifdef ALU_ITER_DIV_EN
            r_rem <= {WIDTH{1'b0}};
`endif
            if (!w_multi) begin
              r_out  <= w_res;
              r_comp <= cmp_flags(bus.A, bus.B);
              r_err  <= w_err;
            end
          end
        end
        S_BUSY: begin
`ifdef ALU_ITER_DIV_EN
          r_acc <= (r_op == OP_MUL) ? w_mul_nxt : w_quo_nxt;
          r_rem <= w_rem_nxt;
`else
          r_acc <= w_mul_nxt;
`endif
          if (r_cnt == {SHW{1'b0}}) begin
            r_out  <= w_iter_res;
            r_comp <= cmp_flags(r_a, r_b);
            r_err  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - SHW'(1);
          end
        end
        S_DONE: begin
          r_out <= r_out;
        end
        default: begin
          r_out <= r_out;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (WIDTH=16): directed cases, handshake corner cases and
// random ops against an arithmetic reference model. Honours ALU_ITER_DIV_EN like the design.
module tb_alu_iter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_iter_if #(.WIDTH(W)) bus ();

  alu_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result from the op definitions; lat counts clock cycles from request to out_valid,
  // including the cycle in which the request is presented.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic e, output logic [2:0] c,
                                output int lat);
    int sa;
    int sb;
    longint unsigned ua;
    longint unsigned ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    c   = (sa > sb) ? 3'b100 : ((sa == sb) ? 3'b010 : 3'b001);
    e   = 1'b0;
    lat = 1;
    r   = 16'h0000;
    case (op)
      4'd0: r = 16'(ua + ub);
      4'd1: r = 16'(ua - ub);
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = 16'(ua << b[3:0]);
      4'd7: r = 16'(ua >> b[3:0]);
      4'd8: r = 16'(sa >>> b[3:0]);
      4'd9: begin r = 16'(ua * ub); lat = 17; end
`ifdef ALU_ITER_DIV_EN
      4'd10: begin
        if (b == 16'h0000) begin r = 16'hFFFF; e = 1'b1; end
        else begin r = 16'(ua / ub); lat = 17; end
      end
      4'd11: begin
        if (b == 16'h0000) begin r = a; e = 1'b1; end
        else begin r = 16'(ua % ub); lat = 17; end
      end
`endif
      default: begin r = 16'h0000; e = 1'b1; end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b);
    logic [15:0] er;
    logic        ee;
    logic [2:0]  ec;
    int          el;
    int          lat;
    bit          busy_ok;
    model(op, a, b, er, ee, ec, el);
    @(negedge clk);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.op        = op;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(el));
    check({tag, " out"}, 32'(bus.out), 32'(er));
    check({tag, " comp"}, 32'(bus.comp), 32'(ec));
    check({tag, " err"}, 32'(bus.err), 32'(ee));
    if (el > 1) check({tag, " busy in_ready low"}, 32'(busy_ok), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bit stable_ok;
    logic [3:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = 16'h0000;
    bus.B         = 16'h0000;
    bus.op        = 4'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out", 32'(bus.out), 32'd0);
    check("reset comp", 32'(bus.comp), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    rst = 1'b0;

    run_op("sub 5-2", 4'd1, 16'd5, 16'd2);
    run_op("sub 2-5", 4'd1, 16'd2, 16'd5);
    run_op("sub neg", 4'd1, 16'hFFFA, 16'hFFFB);
    run_op("sub eq", 4'd1, 16'hFFFA, 16'hFFFA);
    run_op("sub pos-neg", 4'd1, 16'h0002, 16'hFFFA);
    run_op("mul 36", 4'd9, 16'd36, 16'hFFFA);
    run_op("divu 36/5", 4'd10, 16'd36, 16'd5);
    run_op("remu 36%5", 4'd11, 16'd36, 16'd5);
    run_op("divu by 0", 4'd10, 16'd36, 16'd0);
    run_op("remu by 0", 4'd11, 16'd36, 16'd0);
    run_op("undef op", 4'd13, 16'd7, 16'd9);
    run_op("sra", 4'd8, 16'h8010, 16'd4);
    run_op("shl", 4'd6, 16'h00F1, 16'd15);

    // Stall in DONE with a new request held; it must be taken only after the handshake.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 16'd7; bus.B = 16'd3; bus.op = 4'd0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.A = 16'd9; bus.B = 16'd4; bus.op = 4'd1;
    check("stall first out", 32'(bus.out), 32'd10);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out !== 16'd10 || bus.comp !== 3'b100 ||
          bus.err !== 1'b0 || bus.in_ready !== 1'b0) stable_ok = 1'b0;
    end
    check("stall stable", 32'(stable_ok), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("stall release out_valid", 32'(bus.out_valid), 32'd0);
    check("stall release in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("queued out_valid", 32'(bus.out_valid), 32'd1);
    check("queued out", 32'(bus.out), 32'd5);
    check("queued comp", 32'(bus.comp), 32'h4);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // out_ready already high on DONE entry: handshake at the first DONE edge.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 16'h00FF; bus.B = 16'h0F0F; bus.op = 4'd4; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b out", 32'(bus.out), 32'h0FF0);
    check("b2b out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    check("b2b drained", 32'(bus.out_valid), 32'd0);
    check("b2b in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    // Reset in the middle of a multiply discards the partial result.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 16'd36; bus.B = 16'hFFFA; bus.op = 4'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst out", 32'(bus.out), 32'd0);
    check("midrst comp", 32'(bus.comp), 32'd0);
    check("midrst err", 32'(bus.err), 32'd0);
    run_op("add after rst", 4'd0, 16'd1, 16'd1);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
